// File: rtl/pipeline_hazard_ctrl_if.sv
// Hazard-control bundle between the pipeline datapath and pipeline_hazard_ctrl.
// master = datapath side (drives hazard inputs), slave = hazard unit side.
interface pipeline_hazard_ctrl_if;
    logic [4:0]  id_rs;
    logic [4:0]  id_rt;
    logic        id_uses_rs;
    logic        id_uses_rt;
    logic        id_jump;
    logic        id_md_read;
    logic        ex_mem_read;
    logic [4:0]  ex_rd;
    logic        ex_branch_taken;
    logic        ex_md_start;
    logic        ex_md_is_div;
    logic        pc_write;
    logic [1:0]  ifid_choice;
    logic [1:0]  idex_choice;
    logic [1:0]  exmem_choice;
    logic [1:0]  memwb_choice;
    logic        md_busy;
    logic [31:0] stall_cycles;

    modport master (
        output id_rs, id_rt, id_uses_rs, id_uses_rt, id_jump, id_md_read,
        output ex_mem_read, ex_rd, ex_branch_taken, ex_md_start, ex_md_is_div,
        input  pc_write, ifid_choice, idex_choice, exmem_choice, memwb_choice,
        input  md_busy, stall_cycles
    );

    modport slave (
        input  id_rs, id_rt, id_uses_rs, id_uses_rt, id_jump, id_md_read,
        input  ex_mem_read, ex_rd, ex_branch_taken, ex_md_start, ex_md_is_div,
        output pc_write, ifid_choice, idex_choice, exmem_choice, memwb_choice,
        output md_busy, stall_cycles
    );
endinterface

// File: rtl/pipeline_hazard_ctrl.sv
// Hazard/flow-control unit for a 5-stage MIPS pipeline (no delay slot).
// Ports: clk, reset (async active-low), bus (slave): hazard inputs in,
// pipeline-register choice codes (00 flush, 01 load, 10 hold), pc_write,
// md_busy and a saturating stall-cycle counter out.
module pipeline_hazard_ctrl #(
    parameter int MUL_CYCLES = 4,
    parameter int DIV_CYCLES = 32,
    parameter int CNT_W      = 6
) (
    input  logic                  clk,
    input  logic                  reset,
    pipeline_hazard_ctrl_if.slave bus
);

    localparam logic [1:0] C_FLUSH = 2'b00;
    localparam logic [1:0] C_LOAD  = 2'b01;
    localparam logic [1:0] C_HOLD  = 2'b10;

    localparam logic [CNT_W-1:0] MUL_LAT = CNT_W'(MUL_CYCLES - 1);
    localparam logic [CNT_W-1:0] DIV_LAT = CNT_W'(DIV_CYCLES - 1);

    typedef enum logic {
        IDLE    = 1'b0,
        MD_WAIT = 1'b1
    } state_t;

    state_t           r_state;
    state_t           w_state_nxt;
    logic [CNT_W-1:0] r_cnt;
    logic [CNT_W-1:0] w_cnt_nxt;
    logic [CNT_W-1:0] w_md_lat;
    logic [31:0]      r_stall;

    logic       w_busy;
    logic       w_lu;
    logic       w_mdh;
    logic       w_pc_write;
    logic [1:0] w_ifid;
    logic [1:0] w_idex;
    logic [1:0] w_exmem;
    logic [1:0] w_memwb;

    assign w_md_lat = bus.ex_md_is_div ? DIV_LAT : MUL_LAT;
    assign w_busy   = (r_state == MD_WAIT) && reset;

    // r0 is never really written, so a load targeting it cannot create a hazard.
    assign w_lu = bus.ex_mem_read && (bus.ex_rd != 5'd0) &&
                  ((bus.id_uses_rs && (bus.id_rs == bus.ex_rd)) ||
                   (bus.id_uses_rt && (bus.id_rt == bus.ex_rd)));

    assign w_mdh = bus.id_md_read && w_busy;

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            r_state <= IDLE;
            r_cnt   <= '0;
        end else begin
            r_state <= w_state_nxt;
            r_cnt   <= w_cnt_nxt;
        end
    end

    // A new start while waiting restarts the wait with the new op's latency.
    always_comb begin
        w_state_nxt = r_state;
        w_cnt_nxt   = r_cnt;
        unique case (r_state)
            IDLE: begin
                if (bus.ex_md_start) begin
                    w_state_nxt = MD_WAIT;
                    w_cnt_nxt   = w_md_lat;
                end
            end
            MD_WAIT: begin
                if (bus.ex_md_start) begin
                    w_cnt_nxt = w_md_lat;
                end else if (r_cnt == '0) begin
                    w_state_nxt = IDLE;
                end else begin
                    w_cnt_nxt = r_cnt - 1'b1;
                end
            end
            default: begin
                w_state_nxt = IDLE;
                w_cnt_nxt   = '0;
            end
        endcase
    end

    // A taken branch wins over stalls: the ID instruction is wrong-path anyway.
    always_comb begin
        w_pc_write = 1'b1;
        w_ifid     = C_LOAD;
        w_idex     = C_LOAD;
        w_exmem    = C_LOAD;
        w_memwb    = C_LOAD;
        if (!reset) begin
            w_pc_write = 1'b0;
            w_ifid     = C_FLUSH;
            w_idex     = C_FLUSH;
            w_exmem    = C_FLUSH;
            w_memwb    = C_FLUSH;
        end else if (bus.ex_branch_taken) begin
            w_ifid = C_FLUSH;
            w_idex = C_FLUSH;
        end else if (w_lu || w_mdh) begin
            w_pc_write = 1'b0;
            w_ifid     = C_HOLD;
            w_idex     = C_FLUSH;
        end else if (bus.id_jump) begin
            w_ifid = C_FLUSH;
        end
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            r_stall <= '0;
        end else if (!w_pc_write && (r_stall != 32'hFFFF_FFFF)) begin
            r_stall <= r_stall + 32'd1;
        end
    end

    assign bus.pc_write     = w_pc_write;
    assign bus.ifid_choice  = w_ifid;
    assign bus.idex_choice  = w_idex;
    assign bus.exmem_choice = w_exmem;
    assign bus.memwb_choice = w_memwb;
    assign bus.md_busy      = w_busy;
    assign bus.stall_cycles = r_stall;

endmodule

// File: tb/tb_pipeline_hazard_ctrl.sv
// Self-checking bench for pipeline_hazard_ctrl: directed table, multi-cycle
// mult/div and reset sequences, then random stimulus against a reference model.
module tb_pipeline_hazard_ctrl;

    localparam int MULC = 4;
    localparam int DIVC = 32;

    localparam logic [9:0] E_ZERO  = 10'b0_00_00_00_00_0;
    localparam logic [9:0] E_NORM  = 10'b1_01_01_01_01_0;
    localparam logic [9:0] E_STALL = 10'b0_10_00_01_01_0;
    localparam logic [9:0] E_MDST  = 10'b0_10_00_01_01_1;
    localparam logic [9:0] E_JMP   = 10'b1_00_01_01_01_0;
    localparam logic [9:0] E_BR    = 10'b1_00_00_01_01_0;

    logic clk;
    logic reset;

    pipeline_hazard_ctrl_if bus();

    pipeline_hazard_ctrl #(
        .MUL_CYCLES (MULC),
        .DIV_CYCLES (DIVC),
        .CNT_W      (6)
    ) dut (
        .clk   (clk),
        .reset (reset),
        .bus   (bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    int n_checks = 0;
    int n_fail   = 0;

    // Reference model: cycles of mult/div latency still outstanding,
    // and a plain count of stalled cycles.
    int          m_rem;
    logic [31:0] m_stall;

    typedef struct {
        logic [4:0] rs;
        logic [4:0] rt;
        logic       urs;
        logic       urt;
        logic       jump;
        logic       mdr;
        logic       mr;
        logic [4:0] rd;
        logic       br;
        logic [9:0] exp;
    } vec_t;

    vec_t vecs[$];

    function automatic logic [9:0] actual();
        return {bus.pc_write, bus.ifid_choice, bus.idex_choice,
                bus.exmem_choice, bus.memwb_choice, bus.md_busy};
    endfunction

    function automatic logic [9:0] model_out();
        logic busy;
        logic lu;
        logic stall;
        if (!reset) return E_ZERO;
        busy  = (m_rem > 0);
        lu    = bus.ex_mem_read && (bus.ex_rd != 0) &&
                ((bus.id_uses_rs && bus.id_rs == bus.ex_rd) ||
                 (bus.id_uses_rt && bus.id_rt == bus.ex_rd));
        stall = lu || (bus.id_md_read && busy);
        if (bus.ex_branch_taken) return {E_BR[9:1], busy};
        if (stall)               return {E_STALL[9:1], busy};
        if (bus.id_jump)         return {E_JMP[9:1], busy};
        return {E_NORM[9:1], busy};
    endfunction

    task automatic chk(input string name, input logic [31:0] act,
                       input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
        end
    endtask

    task automatic idle_inputs();
        bus.id_rs           = 5'd0;
        bus.id_rt           = 5'd0;
        bus.id_uses_rs      = 1'b0;
        bus.id_uses_rt      = 1'b0;
        bus.id_jump         = 1'b0;
        bus.id_md_read      = 1'b0;
        bus.ex_mem_read     = 1'b0;
        bus.ex_rd           = 5'd0;
        bus.ex_branch_taken = 1'b0;
        bus.ex_md_start     = 1'b0;
        bus.ex_md_is_div    = 1'b0;
    endtask

    // Advance one clock edge and update the model with the pre-edge inputs.
    task automatic tick();
        logic [9:0] e;
        @(posedge clk);
        e = model_out();
        if (reset) begin
            if (!e[9] && m_stall != 32'hFFFF_FFFF) m_stall = m_stall + 1;
            if (bus.ex_md_start)  m_rem = bus.ex_md_is_div ? DIVC : MULC;
            else if (m_rem > 0)   m_rem = m_rem - 1;
        end
        #1;
    endtask

    task automatic do_reset();
        reset = 1'b0;
        idle_inputs();
        m_rem   = 0;
        m_stall = 0;
        repeat (2) @(posedge clk);
        #1;
        reset = 1'b1;
    endtask

    initial begin
        logic [9:0] e;
        reset = 1'b0;
        idle_inputs();
        m_rem   = 0;
        m_stall = 0;
        #2;
        chk("reset_outputs", 32'(actual()), 32'(E_ZERO));
        chk("reset_stall", bus.stall_cycles, 32'd0);
        repeat (2) @(posedge clk);
        #1;
        reset = 1'b1;

        // rs rt urs urt jmp mdr mr rd br
        vecs.push_back('{5'd8, 5'd0, 1'b1, 1'b0, 1'b0, 1'b0, 1'b1, 5'd8, 1'b0, E_STALL});
        vecs.push_back('{5'd8, 5'd0, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 5'd8, 1'b0, E_NORM});
        vecs.push_back('{5'd0, 5'd0, 1'b1, 1'b0, 1'b0, 1'b0, 1'b1, 5'd0, 1'b0, E_NORM});
        vecs.push_back('{5'd1, 5'd9, 1'b1, 1'b1, 1'b0, 1'b0, 1'b1, 5'd9, 1'b0, E_STALL});
        vecs.push_back('{5'd1, 5'd9, 1'b1, 1'b0, 1'b0, 1'b0, 1'b1, 5'd9, 1'b0, E_NORM});
        vecs.push_back('{5'd0, 5'd0, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0, 5'd0, 1'b0, E_JMP});
        vecs.push_back('{5'd8, 5'd0, 1'b1, 1'b0, 1'b1, 1'b0, 1'b1, 5'd8, 1'b1, E_BR});
        vecs.push_back('{5'd0, 5'd0, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0, 5'd0, 1'b0, E_NORM});
        vecs.push_back('{5'd3, 5'd0, 1'b1, 1'b0, 1'b1, 1'b0, 1'b1, 5'd3, 1'b0, E_STALL});
        vecs.push_back('{5'd3, 5'd3, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 5'd3, 1'b0, E_NORM});

        for (int i = 0; i < vecs.size(); i++) begin
            bus.id_rs           = vecs[i].rs;
            bus.id_rt           = vecs[i].rt;
            bus.id_uses_rs      = vecs[i].urs;
            bus.id_uses_rt      = vecs[i].urt;
            bus.id_jump         = vecs[i].jump;
            bus.id_md_read      = vecs[i].mdr;
            bus.ex_mem_read     = vecs[i].mr;
            bus.ex_rd           = vecs[i].rd;
            bus.ex_branch_taken = vecs[i].br;
            @(negedge clk);
            chk($sformatf("vec%0d", i), 32'(actual()), 32'(vecs[i].exp));
            tick();
            chk($sformatf("vec%0d_stall", i), bus.stall_cycles, m_stall);
        end
        chk("table_stall_total", bus.stall_cycles, 32'd3);

        // Divide: 32 stalled cycles with id_md_read held, then free.
        do_reset();
        bus.ex_md_start  = 1'b1;
        bus.ex_md_is_div = 1'b1;
        @(negedge clk);
        chk("div_issue", 32'(actual()), 32'(E_NORM));
        tick();
        bus.ex_md_start = 1'b0;
        bus.id_md_read  = 1'b1;
        for (int c = 0; c < DIVC; c++) begin
            @(negedge clk);
            chk($sformatf("div_wait%0d", c), 32'(actual()), 32'(E_MDST));
            tick();
        end
        @(negedge clk);
        chk("div_done", 32'(actual()), 32'(E_NORM));
        chk("div_stall_cnt", bus.stall_cycles, 32'd32);
        tick();

        // Multiply restarted by a divide while waiting.
        idle_inputs();
        bus.ex_md_start = 1'b1;
        tick();
        tick();
        bus.ex_md_is_div = 1'b1;
        tick();
        idle_inputs();
        bus.id_md_read = 1'b1;
        for (int c = 0; c < DIVC + 2; c++) begin
            @(negedge clk);
            chk($sformatf("restart%0d", c), 32'(actual()), 32'(model_out()));
            tick();
        end

        // Reset in the middle of a divide wait.
        idle_inputs();
        bus.ex_md_start  = 1'b1;
        bus.ex_md_is_div = 1'b1;
        tick();
        idle_inputs();
        repeat (9) tick();
        chk("pre_reset_busy", 32'(bus.md_busy), 32'd1);
        reset = 1'b0;
        m_rem   = 0;
        m_stall = 0;
        #1;
        chk("midreset_out", 32'(actual()), 32'(E_ZERO));
        chk("midreset_stall", bus.stall_cycles, 32'd0);
        @(negedge clk);
        reset = 1'b1;
        #1;
        chk("post_reset_out", 32'(actual()), 32'(E_NORM));
        tick();
        chk("post_reset_stall", bus.stall_cycles, 32'd0);

        // Random stimulus against the model.
        for (int c = 0; c < 3000; c++) begin
            bus.id_rs           = 5'($urandom_range(0, 3));
            bus.id_rt           = 5'($urandom_range(0, 3));
            bus.id_uses_rs      = 1'($urandom_range(0, 1));
            bus.id_uses_rt      = 1'($urandom_range(0, 1));
            bus.id_jump         = ($urandom_range(0, 7) == 0);
            bus.id_md_read      = ($urandom_range(0, 3) == 0);
            bus.ex_mem_read     = ($urandom_range(0, 2) == 0);
            bus.ex_rd           = 5'($urandom_range(0, 3));
            bus.ex_branch_taken = ($urandom_range(0, 9) == 0);
            bus.ex_md_start     = ($urandom_range(0, 19) == 0);
            bus.ex_md_is_div    = ($urandom_range(0, 3) == 0);
            @(negedge clk);
            e = model_out();
            chk($sformatf("rand%0d", c), 32'(actual()), 32'(e));
            tick();
            chk($sformatf("rand%0d_stall", c), bus.stall_cycles, m_stall);
        end

        $display("End of test - %0d assertions evaluated, %0d failures",
                 n_checks, n_fail);
        $finish;
    end

endmodule

// File: doc/pipeline_hazard_ctrl.md
Name: pipeline_hazard_ctrl

Overview:
- Hazard and flow-control unit for the 5-stage MIPS pipeline without delay slot.
- Produces the 2-bit `choice` code consumed by every inter-stage pipeline register (IF/ID, ID/EX, EX/MEM, MEM/WB), plus the PC write enable.
- Detects load-use hazards, branch/jump redirects and multiply/divide busy stalls.
- Tracks mult/div latency with an internal FSM/counter and keeps a stall performance counter.

Parameters:
- MUL_CYCLES, 4: EX-side multiply latency in cycles (>=1).
- DIV_CYCLES, 32: EX-side divide latency in cycles (>=1).
- CNT_W, 6: latency counter width; must hold max(MUL_CYCLES, DIV_CYCLES)-1.

Ports:
- clk  in  1  rising-edge clock
- reset  in  1  asynchronous, active-low reset
- id_rs  in  5  rs field of instruction in ID
- id_rt  in  5  rt field of instruction in ID
- id_uses_rs  in  1  ID instruction reads rs
- id_uses_rt  in  1  ID instruction reads rt
- id_jump  in  1  j/jal decoded in ID (target known in ID)
- id_md_read  in  1  ID instruction is mfhi/mflo/mult/div (needs HI/LO unit)
- ex_mem_read  in  1  EX instruction is a load
- ex_rd  in  5  destination register of EX instruction
- ex_branch_taken  in  1  branch/jr resolved taken in EX
- ex_md_start  in  1  mult/div issuing in EX this cycle
- ex_md_is_div  in  1  qualifies ex_md_start: 1 = divide
- pc_write  out  1  PC update enable
- ifid_choice  out  2  IF/ID register code
- idex_choice  out  2  ID/EX register code
- exmem_choice  out  2  EX/MEM register code
- memwb_choice  out  2  MEM/WB register code
- md_busy  out  1  mult/div unit busy
- stall_cycles  out  32  count of cycles with pc_write=0 since reset

Behaviour:
- Choice encoding: 00 = flush (load zero), 01 = load, 10 = hold. This block never drives 11.
- While reset is low, outputs are forced regardless of the clock:
  - pc_write=0, all choices=00, md_busy=0.
  - stall_cycles=0, FSM=IDLE, counter=0.
- Outputs are combinational from the registered state plus current inputs. There is zero-cycle latency from hazard inputs to choice outputs.
- Load-use hazard (lu) holds when all of the following are true:
  - ex_mem_read=1,
  - ex_rd!=0,
  - (id_uses_rs and id_rs==ex_rd) or (id_uses_rt and id_rt==ex_rd).
- MD hazard (mdh) = id_md_read and md_busy.
- Output priority, highest first:
  1. ex_branch_taken: pc_write=1, ifid=00, idex=00, exmem=01, memwb=01. This overrides lu and mdh because the ID instruction is wrong-path.
  2. lu or mdh (stall): pc_write=0, ifid=10, idex=00 (bubble), exmem=01, memwb=01.
  3. id_jump: pc_write=1, ifid=00, idex=01, exmem=01, memwb=01.
  4. Otherwise: pc_write=1, all choices=01.
- A load-use stall lasts exactly one cycle, because the bubble removes the load from EX.
- FSM states: IDLE, MD_WAIT.
  - IDLE: when ex_md_start=1, load counter with (ex_md_is_div ? DIV_CYCLES : MUL_CYCLES)-1 and go to MD_WAIT.
  - MD_WAIT: md_busy=1; the counter decrements each cycle. When counter==0, go to IDLE on the next edge.
  - md_busy therefore stays high for exactly the configured number of cycles following the start edge.
  - ex_md_start in MD_WAIT reloads the counter from the new op's latency and stays in MD_WAIT. This restarts the wait and is not an error.
  - ex_branch_taken does not cancel MD_WAIT; the issued op is committed.
- stall_cycles increments on each rising edge where pc_write=0 and reset is high. It saturates at 0xFFFFFFFF and does not wrap.
- All state registers use the same asynchronous active-low reset.

Test Plan:
- Load-use: ex_mem_read=1, ex_rd=8, id_rs=8, id_uses_rs=1 → pc_write=0, ifid=10, idex=00, exmem=01, memwb=01, stall_cycles goes 0→1. Next cycle with ex_mem_read=0 → all 01, pc_write=1.
- Zero register: ex_mem_read=1, ex_rd=0, id_rs=0, id_uses_rs=1 → no stall, all 01.
- Divide: ex_md_start=1, ex_md_is_div=1 (DIV_CYCLES=32), then id_md_read=1 held → md_busy and stall for exactly 32 cycles. Cycle 33 → pc_write=1, all 01; stall_cycles=32.
- Priority: ex_branch_taken=1 together with lu and id_jump → pc_write=1, ifid=00, idex=00, exmem=01, memwb=01.
- Jump: id_jump=1 alone → ifid=00, idex/exmem/memwb=01, pc_write=1.
- Reset mid-op: reset low on cycle 10 of a MUL/DIV wait → md_busy=0 and all choices=00 immediately, pc_write=0. After release: all 01, stall_cycles=0, FSM=IDLE.
